// File: rtl/quadrature_pkg.sv
// -----------------------------------------------------------------------------
// quadrature_pkg
// Types and helpers shared by the quadrature encoder front-end:
//   state_t      - decoder FSM states (INIT, TRACK)
//   step_t       - result of one Gray-code transition {inc, dec, err}
//   gray_decode  - classifies a previous -> new {A,B} transition
//   DEFAULT_*    - default parameter values for quadrature_decoder
// -----------------------------------------------------------------------------
package quadrature_pkg;

  localparam int DEFAULT_FILTER_LEN   = 4;
  localparam int DEFAULT_COUNT_WIDTH  = 32;
  localparam int DEFAULT_PERIOD_WIDTH = 16;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  typedef struct packed {
    logic inc;
    logic dec;
    logic err;
  } step_t;

  // {A,B} is a Gray code over four positions: 00->01->11->10 is forward.
  // Converting each pair to its binary position turns the decode into a
  // modulo-4 difference: +1 forward, -1 reverse, 2 means both bits flipped.
  function automatic step_t gray_decode(input logic [1:0] prev_ab,
                                        input logic [1:0] new_ab);
    logic [1:0] pos_prev;
    logic [1:0] pos_new;
    logic [1:0] diff;
    step_t      res;
    pos_prev = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    pos_new  = {new_ab[1],  new_ab[1]  ^ new_ab[0]};
    diff     = pos_new - pos_prev;
    res      = '0;
    case (diff)
      2'd1:    res.inc = 1'b1;
      2'd3:    res.dec = 1'b1;
      2'd2:    res.err = 1'b1;
      default: res     = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quadrature_filter.sv
// -----------------------------------------------------------------------------
// quadrature_filter
// Two-flop synchroniser plus a shared stability filter for the {A,B} pair.
// A new level is accepted only after FILTER_LEN consecutive identical
// synchronised samples; accept pulses for one cycle as filt_ab updates.
//   CLK      in   clock
//   reset_in in   synchronous active-high reset
//   load     in   adopt the current synchronised pair without an accept
//   pins     in   raw asynchronous {A,B}
//   sync_ab  out  synchronised pair (second flop of the chain)
//   filt_ab  out  filtered (accepted) pair
//   accept   out  one-cycle pulse when filt_ab takes a new value
// -----------------------------------------------------------------------------
module quadrature_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic       CLK,
  input  logic       reset_in,
  input  logic       load,
  input  logic [1:0] pins,
  output logic [1:0] sync_ab,
  output logic [1:0] filt_ab,
  output logic       accept
);

  localparam logic [3:0] FLEN = 4'(FILTER_LEN);

  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] cand_p2;
  logic [3:0] cnt_p2;

  function automatic logic [3:0] cnt_sat_inc(input logic [3:0] v);
    return (v >= FLEN) ? FLEN : v + 4'd1;
  endfunction

  // Stage p0/p1: metastability chain. Deliberately not reset so that the
  // chain keeps tracking the pins through a reset pulse; INIT can then
  // adopt the real pin level instead of a forced zero that would later
  // look like a transition.
  always_ff @(posedge CLK) begin
    sync_p0 <= pins;
    sync_p1 <= sync_p0;
  end

  // Stage p2: candidate/counter; filtered pair and accept follow.
  always_ff @(posedge CLK) begin
    if (reset_in) begin
      cand_p2 <= 2'b00;
      cnt_p2  <= 4'd0;
      filt_ab <= 2'b00;
      accept  <= 1'b0;
    end else if (load) begin
      cand_p2 <= sync_p1;
      cnt_p2  <= FLEN;
      filt_ab <= sync_p1;
      accept  <= 1'b0;
    end else begin
      accept <= 1'b0;
      if (sync_p1 != cand_p2) begin
        cand_p2 <= sync_p1;
        cnt_p2  <= 4'd1;
      end else begin
        cnt_p2 <= cnt_sat_inc(cnt_p2);
      end
      // The candidate has been seen FILTER_LEN times in a row.
      if (cnt_p2 == FLEN && cand_p2 != filt_ab) begin
        filt_ab <= cand_p2;
        accept  <= 1'b1;
      end
    end
  end

  assign sync_ab = sync_p1;

endmodule

// File: rtl/quadrature_decoder.sv
// -----------------------------------------------------------------------------
// quadrature_decoder
// 4x quadrature decoder: synchronised, de-glitched A/B -> signed position,
// direction, step pulse, step period and sticky illegal-transition flag.
//   io_mainClk    in   clock
//   io_reset      in   synchronous active-high reset
//   io_quadA/B    in   raw encoder channels (asynchronous)
//   io_clear      in   zero count/error, restart period measurement
//   io_count      out  signed position (wraps modulo 2^COUNT_WIDTH)
//   io_direction  out  1 = last valid step forward, 0 = reverse
//   io_step       out  one-cycle pulse per valid step
//   io_period     out  cycles between the last two steps (saturating)
//   io_error      out  sticky: both channels changed in one accepted update
// -----------------------------------------------------------------------------
module quadrature_decoder
  import quadrature_pkg::*;
#(
  parameter int FILTER_LEN   = DEFAULT_FILTER_LEN,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH,
  parameter int PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH
) (
  input  logic                           io_mainClk,
  input  logic                           io_reset,
  input  logic                           io_quadA,
  input  logic                           io_quadB,
  input  logic                           io_clear,
  output logic signed [COUNT_WIDTH-1:0]  io_count,
  output logic                           io_direction,
  output logic                           io_step,
  output logic        [PERIOD_WIDTH-1:0] io_period,
  output logic                           io_error
);

  localparam logic signed [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic        [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

  state_t                  state;
  logic [1:0]              prev_ab;
  logic [1:0]              sync_ab;
  logic [1:0]              filt_ab;
  logic                    accept;
  logic                    load_filt;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  step_t                   gray;

  function automatic logic [PERIOD_WIDTH-1:0] period_sat_inc(
      input logic [PERIOD_WIDTH-1:0] v);
    return (v == '1) ? v : v + PERIOD_ONE;
  endfunction

  assign load_filt = (state == INIT);

  quadrature_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .CLK      (io_mainClk),
    .reset_in (io_reset),
    .load     (load_filt),
    .pins     ({io_quadA, io_quadB}),
    .sync_ab  (sync_ab),
    .filt_ab  (filt_ab),
    .accept   (accept)
  );

  // filt_ab already holds the new level in the cycle accept is high.
  always_comb gray = gray_decode(prev_ab, filt_ab);

  // Decode stage: FSM, count, direction, period and error registers.
  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      state        <= INIT;
      prev_ab      <= 2'b00;
      io_count     <= '0;
      io_direction <= 1'b0;
      io_step      <= 1'b0;
      period_cnt   <= '0;
      io_period    <= '1;
      io_error     <= 1'b0;
    end else begin
      io_step    <= 1'b0;
      period_cnt <= period_sat_inc(period_cnt);
      case (state)
        INIT: begin
          prev_ab <= sync_ab;
          state   <= TRACK;
        end
        TRACK: begin
          if (accept) begin
            prev_ab <= filt_ab;
            if (!io_clear) begin
              if (gray.err) begin
                io_error <= 1'b1;
              end else if (gray.inc || gray.dec) begin
                io_count     <= gray.inc ? io_count + COUNT_ONE
                                         : io_count - COUNT_ONE;
                io_direction <= gray.inc;
                io_step      <= 1'b1;
                io_period    <= period_cnt;
                period_cnt   <= PERIOD_ONE;
              end
            end
          end
        end
        default: state <= INIT;
      endcase
      // Clear overrides any step or error decoded in the same cycle.
      if (io_clear) begin
        io_count   <= '0;
        io_error   <= 1'b0;
        period_cnt <= '0;
        io_period  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// -----------------------------------------------------------------------------
// tb_quadrature_decoder
// Directed bench for quadrature_decoder. A second instance with a 4-bit
// counter shares all inputs so count wrap-around is observable quickly.
// -----------------------------------------------------------------------------
module tb_quadrature_decoder;

  logic        clk;
  logic        rst;
  logic        quad_a;
  logic        quad_b;
  logic        clear;

  logic [31:0] count;
  logic        direction;
  logic        step;
  logic [15:0] period;
  logic        error;

  logic [3:0]  n_count;
  logic        n_direction;
  logic        n_step;
  logic [15:0] n_period;
  logic        n_error;

  int checks = 0;
  int errors = 0;
  int step_pulses = 0;
  int base;

  quadrature_decoder dut (
    .io_mainClk   (clk),
    .io_reset     (rst),
    .io_quadA     (quad_a),
    .io_quadB     (quad_b),
    .io_clear     (clear),
    .io_count     (count),
    .io_direction (direction),
    .io_step      (step),
    .io_period    (period),
    .io_error     (error)
  );

  quadrature_decoder #(
    .COUNT_WIDTH(4)
  ) dut_narrow (
    .io_mainClk   (clk),
    .io_reset     (rst),
    .io_quadA     (quad_a),
    .io_quadB     (quad_b),
    .io_clear     (clear),
    .io_count     (n_count),
    .io_direction (n_direction),
    .io_step      (n_step),
    .io_period    (n_period),
    .io_error     (n_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (step === 1'b1) step_pulses++;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ab(input logic [1:0] v);
    {quad_a, quad_b} = v;
  endtask

  logic [1:0] fwd [4];
  logic [1:0] rev [4];

  initial begin
    fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[2] = 2'b10; fwd[3] = 2'b00;
    rev[0] = 2'b10; rev[1] = 2'b11; rev[2] = 2'b01; rev[3] = 2'b00;
    rst = 1'b1; clear = 1'b0; set_ab(2'b00);
    tick(4);
    check("reset_count",  count,     64'h0);
    check("reset_flags",  {direction, step, error}, 64'h0);
    check("reset_period", period,    64'hFFFF);
    rst = 1'b0;
    tick(2);

    // Forward: four full cycles, 10 clocks per level.
    base = step_pulses;
    for (int i = 0; i < 16; i++) begin
      set_ab(fwd[i % 4]);
      tick(10);
    end
    check("fwd_count",  count,  64'd16);
    check("fwd_dir",    direction, 64'd1);
    check("fwd_steps",  step_pulses - base, 64'd16);
    check("fwd_period", period, 64'd10);
    check("fwd_error",  error,  64'd0);
    check("fwd_narrow", n_count, 64'h0);

    // Reverse one cycle starting from reset.
    rst = 1'b1; tick(1); rst = 1'b0; tick(2);
    check("rev_reset_count", count, 64'h0);
    for (int i = 0; i < 4; i++) begin
      set_ab(rev[i]);
      tick(10);
    end
    check("rev_count",  count,     64'hFFFF_FFFC);
    check("rev_dir",    direction, 64'd0);
    check("rev_narrow", n_count,   64'hC);

    // Glitch of 3 cycles on A must be rejected.
    base = step_pulses;
    quad_a = 1'b1; tick(3); quad_a = 1'b0; tick(12);
    check("glitch_steps", step_pulses - base, 64'd0);
    check("glitch_count", count, 64'hFFFF_FFFC);

    // Both channels switch together: error, no step, count unchanged.
    set_ab(2'b11); tick(12);
    check("err_flag",  error, 64'd1);
    check("err_count", count, 64'hFFFF_FFFC);
    check("err_steps", step_pulses - base, 64'd0);
    check("err_dir",   direction, 64'd0);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clr_error",  error,  64'd0);
    check("clr_count",  count,  64'd0);
    check("clr_period", period, 64'hFFFF);

    // Wrap: eight forward steps from 11; narrow counter goes 7 -> 8 (0x8).
    for (int i = 0; i < 7; i++) begin
      set_ab(fwd[(i + 2) % 4]);
      tick(10);
    end
    check("wrap_pre_narrow", n_count, 64'h7);
    set_ab(2'b11); tick(10);
    check("wrap_narrow", n_count, 64'h8);
    check("wrap_count",  count,   64'd8);

    // Clear arriving in the same cycle as the decoded step.
    base = step_pulses;
    set_ab(2'b10); tick(7);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("prio_count",  count,   64'd0);
    check("prio_step",   step,    64'd0);
    check("prio_narrow", n_count, 64'h0);
    tick(5);
    check("prio_steps", step_pulses - base, 64'd0);
    set_ab(2'b00); tick(10);
    check("prio_prev_updated", count, 64'd1);

    // Reset with pins parked at 11: nothing spurious, then exact latency.
    set_ab(2'b01); tick(10);
    set_ab(2'b11); tick(10);
    check("mid_pre_count", count, 64'd3);
    base = step_pulses;
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(12);
    check("mid_count",  count, 64'd0);
    check("mid_steps",  step_pulses - base, 64'd0);
    check("mid_error",  error, 64'd0);
    set_ab(2'b10);
    tick(7);
    check("lat_before", count, 64'd0);
    check("lat_step_before", step, 64'd0);
    tick(1);
    check("lat_count", count, 64'd1);
    check("lat_step",  step,  64'd1);
    check("lat_dir",   direction, 64'd1);
    tick(1);
    check("lat_step_one_cycle", step, 64'd0);

    // Period saturation after a long stall.
    tick(70000);
    set_ab(2'b00); tick(10);
    check("sat_period", period, 64'hFFFF);
    check("sat_count",  count,  64'd2);
    check("narrow_flags", {n_direction, n_error, n_step, n_period},
          {1'b1, 1'b0, 1'b0, 16'hFFFF});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
